// File: rtl/pit_pkg.sv
// Shared types and constants for the point-in-triangle sequencer: FSM encoding,
// orientation result width and the operand selections used by each CALC step.
package pit_pkg;

    localparam int PIT_COORD_W = 10;

    function automatic int ori_width(input int coord_w);
        return 2 * coord_w + 3;
    endfunction

    localparam int ORI_W = ori_width(PIT_COORD_W);

    typedef enum logic [3:0] {
        CAP_P1  = 4'd0,
        CAP_P2  = 4'd1,
        CAP_P3  = 4'd2,
        CAP_PT  = 4'd3,
        CALC_A  = 4'd4,
        CALC_E0 = 4'd5,
        CALC_E1 = 4'd6,
        CALC_E2 = 4'd7,
        RESULT  = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        SEL_P1 = 2'd0,
        SEL_P2 = 2'd1,
        SEL_P3 = 2'd2,
        SEL_PT = 2'd3
    } pt_sel_t;

    typedef struct packed {
        pt_sel_t a;
        pt_sel_t b;
        pt_sel_t c;
    } ori_ops_t;

    localparam ori_ops_t OPS_AREA = '{a: SEL_P1, b: SEL_P2, c: SEL_P3};
    localparam ori_ops_t OPS_E0   = '{a: SEL_P1, b: SEL_P2, c: SEL_PT};
    localparam ori_ops_t OPS_E1   = '{a: SEL_P2, b: SEL_P3, c: SEL_PT};
    localparam ori_ops_t OPS_E2   = '{a: SEL_P3, b: SEL_P1, c: SEL_PT};

endpackage

// File: rtl/tri_orient.sv
// Combinational orientation test: r = (ax-cx)*(by-cy) - (bx-cx)*(ay-cy)
// on unsigned coordinates; the result width is sized so it can never overflow.
module tri_orient #(
    parameter int COORD_W = 10,
    parameter int ORI_W   = 2 * COORD_W + 3
) (
    input  logic        [COORD_W-1:0] ax_i,
    input  logic        [COORD_W-1:0] ay_i,
    input  logic        [COORD_W-1:0] bx_i,
    input  logic        [COORD_W-1:0] by_i,
    input  logic        [COORD_W-1:0] cx_i,
    input  logic        [COORD_W-1:0] cy_i,
    output logic signed [ORI_W-1:0]   r_o
);

    localparam int DW = COORD_W + 1;
    localparam int PW = 2 * COORD_W + 2;

    logic signed [DW-1:0] dax, day, dbx, dby;
    logic signed [PW-1:0] dax_e, day_e, dbx_e, dby_e;
    logic signed [PW-1:0] prod0, prod1;

    // Zero-extend first so the differences are exact in COORD_W+1 signed bits.
    assign dax = $signed({1'b0, ax_i}) - $signed({1'b0, cx_i});
    assign day = $signed({1'b0, ay_i}) - $signed({1'b0, cy_i});
    assign dbx = $signed({1'b0, bx_i}) - $signed({1'b0, cx_i});
    assign dby = $signed({1'b0, by_i}) - $signed({1'b0, cy_i});

    assign dax_e = PW'(dax);
    assign day_e = PW'(day);
    assign dbx_e = PW'(dbx);
    assign dby_e = PW'(dby);

    assign prod0 = dax_e * dby_e;
    assign prod1 = dbx_e * day_e;

    assign r_o = ORI_W'(prod0) - ORI_W'(prod1);

endmodule

// File: rtl/point_in_triangle_ctrl.sv
// Captures three vertices and a test point on selPonto rising edges, then runs
// four orientation evaluations through one shared datapath to light LEDG/LEDR.
module point_in_triangle_ctrl
    import pit_pkg::*;
#(
    parameter int COORD_W = PIT_COORD_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic               selPonto,
    output logic [1:0]         pt_idx,
    output logic               busy,
    output logic               done,
    output logic               LEDG,
    output logic               LEDR,
    output logic               degenerate
);

    localparam int OW = ori_width(COORD_W);

    state_t state_q, state_d;
    logic   sel_q;
    logic   cap;

    logic [COORD_W-1:0] x_q [4];
    logic [COORD_W-1:0] x_d [4];
    logic [COORD_W-1:0] y_q [4];
    logic [COORD_W-1:0] y_d [4];

    // Flags kept for AREA, E0 and E1; the E2 flags feed the result directly.
    logic [2:0] pos_q, pos_d;
    logic [2:0] neg_q, neg_d;

    logic ledg_q, ledg_d;
    logic ledr_q, ledr_d;
    logic degen_q, degen_d;
    logic done_q, done_d;

    ori_ops_t          ops;
    logic [1:0]        step;
    logic signed [OW-1:0] ori;
    logic              ori_pos, ori_neg;
    logic              any_pos, any_neg, is_degen, is_inside;

    assign cap = selPonto & ~sel_q;

    always_comb begin
        ops  = OPS_AREA;
        step = 2'd0;
        case (state_q)
            CALC_E0: begin ops = OPS_E0; step = 2'd1; end
            CALC_E1: begin ops = OPS_E1; step = 2'd2; end
            CALC_E2: begin ops = OPS_E2; step = 2'd3; end
            default: ;
        endcase
    end

    tri_orient #(
        .COORD_W (COORD_W),
        .ORI_W   (OW)
    ) u_orient (
        .ax_i (x_q[ops.a]),
        .ay_i (y_q[ops.a]),
        .bx_i (x_q[ops.b]),
        .by_i (y_q[ops.b]),
        .cx_i (x_q[ops.c]),
        .cy_i (y_q[ops.c]),
        .r_o  (ori)
    );

    assign ori_neg = ori[OW-1];
    assign ori_pos = ~ori[OW-1] & (ori != '0);

    // Evaluated during CALC_E2, where ori holds the E2 orientation.
    assign any_pos   = pos_q[1] | pos_q[2] | ori_pos;
    assign any_neg   = neg_q[1] | neg_q[2] | ori_neg;
    assign is_degen  = ~pos_q[0] & ~neg_q[0];
    assign is_inside = ~is_degen & ~(any_pos & any_neg);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        pos_d   = pos_q;
        neg_d   = neg_q;
        ledg_d  = ledg_q;
        ledr_d  = ledr_q;
        degen_d = degen_q;
        done_d  = 1'b0;

        case (state_q)
            CAP_P1, CAP_P2, CAP_P3, CAP_PT: begin
                if (cap) begin
                    x_d[state_q[1:0]] = px;
                    y_d[state_q[1:0]] = py;
                    case (state_q)
                        CAP_P1:  state_d = CAP_P2;
                        CAP_P2:  state_d = CAP_P3;
                        CAP_P3:  state_d = CAP_PT;
                        default: state_d = CALC_A;
                    endcase
                end
            end
            CALC_A, CALC_E0, CALC_E1: begin
                pos_d[step] = ori_pos;
                neg_d[step] = ori_neg;
                case (state_q)
                    CALC_A:  state_d = CALC_E0;
                    CALC_E0: state_d = CALC_E1;
                    default: state_d = CALC_E2;
                endcase
            end
            CALC_E2: begin
                degen_d = is_degen;
                ledg_d  = is_inside;
                ledr_d  = ~is_inside;
                done_d  = 1'b1;
                state_d = RESULT;
            end
            RESULT: begin
                if (cap) begin
                    x_d[0]  = px;
                    y_d[0]  = py;
                    ledg_d  = 1'b0;
                    ledr_d  = 1'b0;
                    degen_d = 1'b0;
                    state_d = CAP_P2;
                end
            end
            default: state_d = CAP_P1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CAP_P1;
            sel_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            pos_q   <= '0;
            neg_q   <= '0;
            ledg_q  <= 1'b0;
            ledr_q  <= 1'b0;
            degen_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= selPonto;
            x_q     <= x_d;
            y_q     <= y_d;
            pos_q   <= pos_d;
            neg_q   <= neg_d;
            ledg_q  <= ledg_d;
            ledr_q  <= ledr_d;
            degen_q <= degen_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        pt_idx = 2'd0;
        case (state_q)
            CAP_P2:  pt_idx = 2'd1;
            CAP_P3:  pt_idx = 2'd2;
            CAP_PT:  pt_idx = 2'd3;
            default: pt_idx = 2'd0;
        endcase
    end

    assign busy       = (state_q == CALC_A) || (state_q == CALC_E0) ||
                        (state_q == CALC_E1) || (state_q == CALC_E2);
    assign done       = done_q;
    assign LEDG       = ledg_q;
    assign LEDR       = ledr_q;
    assign degenerate = degen_q;

endmodule

// File: tb/tb_point_in_triangle_ctrl.sv
// Directed bench for point_in_triangle_ctrl with hand-computed LED results.
module tb_point_in_triangle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] px = '0;
    logic [9:0] py = '0;
    logic       selPonto = 1'b0;
    logic [1:0] pt_idx;
    logic       busy, done, LEDG, LEDR, degenerate;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    point_in_triangle_ctrl #(.COORD_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .px         (px),
        .py         (py),
        .selPonto   (selPonto),
        .pt_idx     (pt_idx),
        .busy       (busy),
        .done       (done),
        .LEDG       (LEDG),
        .LEDR       (LEDR),
        .degenerate (degenerate)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Raises selPonto with a coordinate for 'hold' cycles; returns on the
    // falling edge after the capture edge with selPonto low again.
    task automatic cap(input int x, input int y, input int hold);
        @(negedge clk);
        px = 10'(x);
        py = 10'(y);
        selPonto = 1'b1;
        repeat (hold) @(negedge clk);
        selPonto = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic exp_g, input logic exp_d);
        chk({tag, ".busy0"}, 32'(busy), 1);
        chk({tag, ".done0"}, 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, ".done_early"}, 32'(done), 0);
        end
        @(negedge clk);
        chk({tag, ".done"}, 32'(done), 1);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".LEDG"}, 32'(LEDG), 32'(exp_g));
        chk({tag, ".LEDR"}, 32'(LEDR), 32'(!exp_g));
        chk({tag, ".degen"}, 32'(degenerate), 32'(exp_d));
        chk({tag, ".idx"}, 32'(pt_idx), 0);
        @(negedge clk);
        chk({tag, ".done_pulse"}, 32'(done), 0);
        chk({tag, ".LEDG_hold"}, 32'(LEDG), 32'(exp_g));
    endtask

    task automatic run_tri(input string tag,
                           input int x1, input int y1, input int x2, input int y2,
                           input int x3, input int y3, input int xt, input int yt,
                           input logic exp_g, input logic exp_d);
        cap(x1, y1, 1);
        chk({tag, ".idx1"}, 32'(pt_idx), 1);
        chk({tag, ".clrG"}, 32'(LEDG), 0);
        chk({tag, ".clrR"}, 32'(LEDR), 0);
        cap(x2, y2, 1);
        chk({tag, ".idx2"}, 32'(pt_idx), 2);
        cap(x3, y3, 1);
        chk({tag, ".idx3"}, 32'(pt_idx), 3);
        cap(xt, yt, 1);
        check_result(tag, exp_g, exp_d);
    endtask

    initial begin
        #1;
        chk("rst.idx", 32'(pt_idx), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.done", 32'(done), 0);
        chk("rst.LEDG", 32'(LEDG), 0);
        chk("rst.LEDR", 32'(LEDR), 0);
        chk("rst.degen", 32'(degenerate), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_tri("edge",    2, 2, 0, 0, 4, 0, 3, 1, 1'b1, 1'b0);
        run_tri("in",      2, 2, 0, 0, 4, 0, 2, 1, 1'b1, 1'b0);
        run_tri("wind",    0, 0, 2, 2, 4, 0, 2, 1, 1'b1, 1'b0);
        run_tri("out",     2, 2, 0, 0, 4, 0, 5, 5, 1'b0, 1'b0);
        run_tri("big_out", 1023, 0, 0, 1023, 0, 0, 1023, 1023, 1'b0, 1'b0);
        run_tri("big_vtx", 1023, 0, 0, 1023, 0, 0, 0, 0, 1'b1, 1'b0);
        run_tri("collin",  0, 0, 1, 1, 2, 2, 1, 1, 1'b0, 1'b1);

        // Captures requested while computing are dropped.
        cap(2, 2, 1);
        cap(0, 0, 1);
        cap(4, 0, 1);
        cap(3, 1, 1);
        selPonto = 1'b1;
        @(negedge clk);
        chk("calc.idx_a", 32'(pt_idx), 0);
        chk("calc.busy_a", 32'(busy), 1);
        selPonto = 1'b0;
        @(negedge clk);
        selPonto = 1'b1;
        @(negedge clk);
        chk("calc.idx_b", 32'(pt_idx), 0);
        selPonto = 1'b0;
        @(negedge clk);
        chk("calc.done", 32'(done), 1);
        chk("calc.LEDG", 32'(LEDG), 1);
        chk("calc.idx_c", 32'(pt_idx), 0);
        @(negedge clk);
        chk("calc.noq_idx", 32'(pt_idx), 0);
        chk("calc.noq_LEDG", 32'(LEDG), 1);

        // A long selPonto pulse yields a single capture.
        cap(5, 5, 3);
        chk("hold.idx", 32'(pt_idx), 1);
        chk("hold.LEDG", 32'(LEDG), 0);
        cap(0, 0, 1);
        cap(10, 0, 1);
        chk("hold.idx3", 32'(pt_idx), 3);
        cap(6, 6, 1);
        check_result("hold", 1'b0, 1'b0);

        // Asynchronous reset mid-capture.
        cap(1, 1, 1);
        cap(9, 9, 1);
        chk("mid.idx_pre", 32'(pt_idx), 2);
        #2 rst = 1'b1;
        #1;
        chk("mid.idx", 32'(pt_idx), 0);
        chk("mid.busy", 32'(busy), 0);
        chk("mid.LEDG", 32'(LEDG), 0);
        chk("mid.LEDR", 32'(LEDR), 0);
        @(negedge clk);
        rst = 1'b0;
        run_tri("post_rst", 2, 2, 0, 0, 4, 0, 3, 1, 1'b1, 1'b0);

        // Asynchronous reset while a result is displayed.
        #2 rst = 1'b1;
        #1;
        chk("res_rst.LEDG", 32'(LEDG), 0);
        chk("res_rst.LEDR", 32'(LEDR), 0);
        chk("res_rst.idx", 32'(pt_idx), 0);
        @(negedge clk);
        rst = 1'b0;
        cap(7, 7, 1);
        chk("res_rst.idx1", 32'(pt_idx), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
